// File: rtl/multicycle_computer_pkg.sv
// Shared types and field helpers for the multicycle computer.
package multicycle_computer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LDI    = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_SHL    = 4'h7,
    OP_SHR    = 4'h8,
    OP_IN     = 4'h9,
    OP_OUT    = 4'hA,
    OP_BZ     = 4'hB,
    OP_JMP    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } opcode_t;

  localparam int OPW = 4;

  // Instruction layout, MSB first: opcode | rd | ra | rb | imm
  function automatic int instr_width(input int raw, input int dw);
    return OPW + 3 * raw + dw;
  endfunction

  function automatic int imm_lsb(input int dw);
    return 0 * dw;
  endfunction

  function automatic int rb_lsb(input int dw);
    return dw;
  endfunction

  function automatic int ra_lsb(input int raw, input int dw);
    return dw + raw;
  endfunction

  function automatic int rd_lsb(input int raw, input int dw);
    return dw + 2 * raw;
  endfunction

  function automatic int op_lsb(input int raw, input int dw);
    return dw + 3 * raw;
  endfunction

  // Opcodes LDI..IN produce a register result
  function automatic logic writes_reg(input opcode_t op);
    return (op >= OP_LDI) && (op <= OP_IN);
  endfunction

  // Opcodes ADD..IN refresh the zero flag
  function automatic logic updates_zf(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_IN);
  endfunction

endpackage

// File: rtl/multicycle_computer_regfile.sv
// NREG x DW register file: two combinational read ports, a debug read
// port and one synchronous write port with synchronous clear.
module mc_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RAW  = 2
)(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_we,
  input  logic [RAW-1:0] i_wa,
  input  logic [DW-1:0]  i_wd,
  input  logic [RAW-1:0] i_ra_a,
  output logic [DW-1:0]  o_rd_a,
  input  logic [RAW-1:0] i_ra_b,
  output logic [DW-1:0]  o_rd_b,
  input  logic [RAW-1:0] i_dbg_sel,
  output logic [DW-1:0]  o_dbg
);

  logic [DW-1:0] r_mem [NREG];

  // Clear all entries on reset, otherwise commit the single write port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd_a = r_mem[i_ra_a];
  assign o_rd_b = r_mem[i_ra_b];
  assign o_dbg  = r_mem[i_dbg_sel];

endmodule

// File: rtl/multicycle_computer.sv
// Three-cycle-per-instruction accumulator-free computer: FETCH latches the
// instruction, EXEC computes and latches results, WB commits them.
//
// state | meaning
// IDLE  | waiting for RUN
// FETCH | latch INSTR_DATA into IR, PC+1
// EXEC  | read operands, latch ALU result, next flags, branch decision
// WB    | commit register write, DATA_OUT, flags, branch target
// HALT  | frozen until RST
module multicycle_computer
  import multicycle_computer_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int PCW  = 6,
  localparam int RAW = $clog2(NREG),
  localparam int IW  = instr_width(RAW, DW)
)(
  input  logic           CLK,
  input  logic           RST,
  input  logic           RUN,
  output logic [PCW-1:0] INSTR_ADDR,
  input  logic [IW-1:0]  INSTR_DATA,
  input  logic [DW-1:0]  DATA_IN,
  output logic [DW-1:0]  DATA_OUT,
  output logic [PCW-1:0] PC,
  output logic [2:0]     STATE,
  output logic           BUSY,
  output logic           HALTED,
  output logic           ZF,
  output logic           CF,
  input  logic [RAW-1:0] DBG_SEL,
  output logic [DW-1:0]  DBG_DATA
);

  localparam int OP_L  = op_lsb(RAW, DW);
  localparam int RD_L  = rd_lsb(RAW, DW);
  localparam int RA_L  = ra_lsb(RAW, DW);
  localparam int RB_L  = rb_lsb(DW);
  localparam int IMM_L = imm_lsb(DW);

  state_t         r_state, w_state_n;
  logic [PCW-1:0] r_pc;
  logic [IW-1:0]  r_ir;
  logic [DW-1:0]  r_dout, r_res;
  logic           r_zf, r_cf, r_zf_nxt, r_cf_nxt, r_take;

  opcode_t        w_op;
  logic [RAW-1:0] w_rd, w_ra, w_rb;
  logic [DW-1:0]  w_imm, w_a, w_b, w_res;
  logic [DW:0]    w_sum;
  logic           w_zf_n, w_cf_n, w_take, w_we;

  assign w_op  = opcode_t'(r_ir[OP_L +: OPW]);
  assign w_rd  = r_ir[RD_L +: RAW];
  assign w_ra  = r_ir[RA_L +: RAW];
  assign w_rb  = r_ir[RB_L +: RAW];
  assign w_imm = r_ir[IMM_L +: DW];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_we  = (r_state == S_WB) && writes_reg(w_op);

  mc_regfile #(.DW(DW), .NREG(NREG), .RAW(RAW)) u_rf (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_we      (w_we),
    .i_wa      (w_rd),
    .i_wd      (r_res),
    .i_ra_a    (w_ra),
    .o_rd_a    (w_a),
    .i_ra_b    (w_rb),
    .o_rd_b    (w_b),
    .i_dbg_sel (DBG_SEL),
    .o_dbg     (DBG_DATA)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state decode; unused encodings fall back to IDLE
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (RUN) w_state_n = S_FETCH;
      S_FETCH: w_state_n = S_EXEC;
      S_EXEC:  w_state_n = S_WB;
      S_WB:    w_state_n = (w_op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:  w_state_n = S_HALT;
      default: w_state_n = S_IDLE;
    endcase
  end

  // ALU, next flags and branch decision from the current IR and operands
  always_comb begin
    w_res  = '0;
    w_zf_n = r_zf;
    w_cf_n = r_cf;
    w_take = 1'b0;
    case (w_op)
      OP_LDI: w_res = w_imm;
      OP_ADD: begin
        w_res  = w_sum[DW-1:0];
        w_cf_n = w_sum[DW];
      end
      OP_SUB: begin
        w_res  = w_a - w_b;
        w_cf_n = (w_a < w_b);
      end
      OP_AND: w_res = w_a & w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_SHL: begin
        w_res  = {w_a[DW-2:0], 1'b0};
        w_cf_n = w_a[DW-1];
      end
      OP_SHR: begin
        w_res  = {1'b0, w_a[DW-1:1]};
        w_cf_n = w_a[0];
      end
      OP_IN:  w_res = DATA_IN;
      OP_OUT: w_res = w_a;
      OP_BZ:  w_take = (w_a == '0);
      OP_JMP: w_take = 1'b1;
      default: ;
    endcase
    if (updates_zf(w_op)) w_zf_n = (w_res == '0);
  end

  // Datapath registers: results are staged in EXEC and committed in WB so
  // that a reset mid-instruction discards them
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_dout   <= '0;
      r_res    <= '0;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
      r_zf_nxt <= 1'b0;
      r_cf_nxt <= 1'b0;
      r_take   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir <= INSTR_DATA;
          r_pc <= r_pc + PCW'(1);
        end
        S_EXEC: begin
          r_res    <= w_res;
          r_zf_nxt <= w_zf_n;
          r_cf_nxt <= w_cf_n;
          r_take   <= w_take;
        end
        S_WB: begin
          r_zf <= r_zf_nxt;
          r_cf <= r_cf_nxt;
          if (w_op == OP_OUT) r_dout <= r_res;
          if (r_take) r_pc <= r_ir[PCW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign INSTR_ADDR = r_pc;
  assign PC         = r_pc;
  assign STATE      = r_state;
  assign BUSY       = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_WB);
  assign HALTED     = (r_state == S_HALT);
  assign DATA_OUT   = r_dout;
  assign ZF         = r_zf;
  assign CF         = r_cf;

endmodule

// File: tb/tb_multicycle_computer.sv
// Directed bench for multicycle_computer: default-size instance plus a
// PCW=3 instance for program-counter wrap.
module tb_multicycle_computer;

  localparam int IW = 18;

  logic          clk;
  logic          rst, run;
  logic [5:0]    instr_addr;
  logic [IW-1:0] instr_data;
  logic [7:0]    data_in, data_out, dbg_data;
  logic [5:0]    pc;
  logic [2:0]    state;
  logic          busy, halted, zf, cf;
  logic [1:0]    dbg_sel;
  logic [IW-1:0] rom [0:63];

  logic          rst3, run3;
  logic [2:0]    instr_addr3, pc3, state3;
  logic [IW-1:0] instr_data3;
  logic [7:0]    data_out3, dbg_data3;
  logic          busy3, halted3, zf3, cf3;
  logic [IW-1:0] rom3 [0:7];

  int n_checks = 0;
  int n_fail   = 0;

  assign instr_data  = rom[instr_addr];
  assign instr_data3 = rom3[instr_addr3];

  multicycle_computer dut (
    .CLK(clk), .RST(rst), .RUN(run),
    .INSTR_ADDR(instr_addr), .INSTR_DATA(instr_data),
    .DATA_IN(data_in), .DATA_OUT(data_out),
    .PC(pc), .STATE(state), .BUSY(busy), .HALTED(halted),
    .ZF(zf), .CF(cf), .DBG_SEL(dbg_sel), .DBG_DATA(dbg_data)
  );

  multicycle_computer #(.DW(8), .NREG(4), .PCW(3)) dut3 (
    .CLK(clk), .RST(rst3), .RUN(run3),
    .INSTR_ADDR(instr_addr3), .INSTR_DATA(instr_data3),
    .DATA_IN(8'h00), .DATA_OUT(data_out3),
    .PC(pc3), .STATE(state3), .BUSY(busy3), .HALTED(halted3),
    .ZF(zf3), .CF(cf3), .DBG_SEL(2'd0), .DBG_DATA(dbg_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] enc(input logic [3:0] op, input int rd,
                                        input int ra, input int rb, input logic [7:0] imm);
    return {op, 2'(rd), 2'(ra), 2'(rb), imm};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 64; i++) rom[i] = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    run = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic start_run;
    run = 1'b1;
    step(1);
    run = 1'b0;
  endtask

  task automatic rd_reg(input int k, output logic [7:0] v);
    dbg_sel = 2'(k);
    #1;
    v = dbg_data;
  endtask

  task automatic wait_halt(input int max, output int cyc);
    cyc = 0;
    while (cyc < max && !halted) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    do_reset;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (pc !== 6'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
    n_checks++; if ({zf, cf, busy, halted} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got zf,cf,busy,halted=%b expected 0000", {zf, cf, busy, halted}); end
    for (int r = 0; r < 4; r++) begin
      rd_reg(r, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00", r, v); end
    end
  endtask

  task automatic test_program;
    int c;
    logic [7:0] v;
    clear_rom;
    rom[0] = enc(4'h1, 1, 0, 0, 8'd5);
    rom[1] = enc(4'h1, 2, 0, 0, 8'd3);
    rom[2] = enc(4'h2, 3, 1, 2, 8'd0);
    rom[3] = enc(4'hA, 0, 3, 0, 8'd0);
    rom[4] = enc(4'hF, 0, 0, 0, 8'd0);
    do_reset;
    start_run;
    n_checks++; if (state !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL prog_fetch: got state %0d busy %b expected 1 1", state, busy); end
    step(1);
    n_checks++; if (state !== 3'd2 || pc !== 6'd1) begin n_fail++; $display("FAIL prog_exec: got state %0d pc %0d expected 2 1", state, pc); end
    step(1);
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL prog_wb: got state %0d expected 3", state); end
    step(1);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL prog_refetch: got state %0d expected 1", state); end
    wait_halt(60, c);
    c = c + 3;
    n_checks++; if (c !== 15) begin n_fail++; $display("FAIL prog_cycles: got %0d expected 15", c); end
    n_checks++; if (data_out !== 8'h08) begin n_fail++; $display("FAIL prog_dout: got %h expected 08", data_out); end
    n_checks++; if (halted !== 1'b1 || busy !== 1'b0 || state !== 3'd4) begin n_fail++; $display("FAIL prog_halted: got halted %b busy %b state %0d expected 1 0 4", halted, busy, state); end
    n_checks++; if (pc !== 6'd5) begin n_fail++; $display("FAIL prog_pc: got %0d expected 5", pc); end
    rd_reg(3, v);
    n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL prog_r3: got %h expected 08", v); end
    run = 1'b1;
    step(2);
    run = 1'b0;
    step(2);
    n_checks++; if (state !== 3'd4 || pc !== 6'd5) begin n_fail++; $display("FAIL halt_hold: got state %0d pc %0d expected 4 5", state, pc); end
  endtask

  task automatic test_arith;
    int c;
    logic [7:0] v;
    int         ex_reg [7] = '{3, 0, 3, 0, 3, 2, 1};
    logic [7:0] ex_val [7] = '{8'h03, 8'hCF, 8'h00, 8'h86, 8'h07, 8'h1E, 8'h61};
    logic       ex_zf  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ex_cf  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    clear_rom;
    rom[0] = enc(4'h1, 1, 0, 0, 8'hFF);
    rom[1] = enc(4'h1, 2, 0, 0, 8'h01);
    rom[2] = enc(4'h2, 3, 1, 2, 8'h00);
    rom[3] = enc(4'h3, 0, 2, 1, 8'h00);
    rom[4] = enc(4'h1, 1, 0, 0, 8'h00);
    rom[5] = enc(4'hF, 0, 0, 0, 8'h00);
    do_reset;
    start_run;
    step(9);
    rd_reg(3, v);
    n_checks++; if (v !== 8'h00 || zf !== 1'b1 || cf !== 1'b1) begin n_fail++; $display("FAIL add_carry: got r3 %h zf %b cf %b expected 00 1 1", v, zf, cf); end
    step(3);
    rd_reg(0, v);
    n_checks++; if (v !== 8'h02 || zf !== 1'b0 || cf !== 1'b1) begin n_fail++; $display("FAIL sub_borrow: got r0 %h zf %b cf %b expected 02 0 1", v, zf, cf); end
    step(3);
    rd_reg(1, v);
    n_checks++; if (v !== 8'h00 || zf !== 1'b0 || cf !== 1'b1) begin n_fail++; $display("FAIL ldi_keeps_flags: got r1 %h zf %b cf %b expected 00 0 1", v, zf, cf); end
    wait_halt(20, c);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL arith_a_halt: got %b expected 1", halted); end

    clear_rom;
    rom[0] = enc(4'h1, 1, 0, 0, 8'hC3);
    rom[1] = enc(4'h1, 2, 0, 0, 8'h0F);
    rom[2] = enc(4'h4, 3, 1, 2, 8'h00);
    rom[3] = enc(4'h5, 0, 1, 2, 8'h00);
    rom[4] = enc(4'h6, 3, 1, 1, 8'h00);
    rom[5] = enc(4'h7, 0, 1, 0, 8'h00);
    rom[6] = enc(4'h8, 3, 2, 0, 8'h00);
    rom[7] = enc(4'h7, 2, 2, 0, 8'h00);
    rom[8] = enc(4'h8, 1, 1, 0, 8'h00);
    rom[9] = enc(4'hF, 0, 0, 0, 8'h00);
    do_reset;
    start_run;
    step(6);
    for (int k = 0; k < 7; k++) begin
      step(3);
      rd_reg(ex_reg[k], v);
      n_checks++;
      if (v !== ex_val[k] || zf !== ex_zf[k] || cf !== ex_cf[k]) begin
        n_fail++;
        $display("FAIL logic_op%0d: got r%0d=%h zf %b cf %b expected %h %b %b", k + 2, ex_reg[k], v, zf, cf, ex_val[k], ex_zf[k], ex_cf[k]);
      end
    end
  endtask

  task automatic test_loop;
    int c, subs;
    logic [7:0] v;
    clear_rom;
    rom[0] = enc(4'h1, 1, 0, 0, 8'd3);
    rom[1] = enc(4'h1, 2, 0, 0, 8'd1);
    rom[2] = enc(4'h3, 1, 1, 2, 8'd0);
    rom[3] = enc(4'hB, 0, 1, 0, 8'd6);
    rom[4] = enc(4'hC, 0, 0, 0, 8'd2);
    rom[5] = enc(4'h0, 0, 0, 0, 8'd0);
    rom[6] = enc(4'hF, 0, 0, 0, 8'd0);
    do_reset;
    start_run;
    c = 0;
    subs = 0;
    while (c < 200 && !halted) begin
      if (state == 3'd1 && pc == 6'd2) subs++;
      step(1);
      c++;
    end
    n_checks++; if (halted !== 1'b1 || c !== 33) begin n_fail++; $display("FAIL loop_halt: got halted %b after %0d cycles expected 1 after 33", halted, c); end
    n_checks++; if (subs !== 3) begin n_fail++; $display("FAIL loop_subs: got %0d expected 3", subs); end
    rd_reg(1, v);
    n_checks++; if (v !== 8'h00 || zf !== 1'b1 || cf !== 1'b0) begin n_fail++; $display("FAIL loop_r1: got r1 %h zf %b cf %b expected 00 1 0", v, zf, cf); end
    n_checks++; if (pc !== 6'd7) begin n_fail++; $display("FAIL loop_pc: got %0d expected 7", pc); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) rom3[i] = '0;
    rst3 = 1'b1;
    step(1);
    rst3 = 1'b0;
    run3 = 1'b1;
    step(1);
    run3 = 1'b0;
    step(19);
    n_checks++; if (pc3 !== 3'd7) begin n_fail++; $display("FAIL wrap_pre: got %0d expected 7", pc3); end
    step(3);
    n_checks++; if (pc3 !== 3'd0 || busy3 !== 1'b1) begin n_fail++; $display("FAIL wrap_pc: got pc %0d busy %b expected 0 1", pc3, busy3); end
    rom3[0] = enc(4'hC, 0, 0, 0, 8'd7);
    rst3 = 1'b1;
    step(1);
    rst3 = 1'b0;
    run3 = 1'b1;
    step(1);
    run3 = 1'b0;
    step(3);
    n_checks++; if (pc3 !== 3'd7 || state3 !== 3'd1) begin n_fail++; $display("FAIL jmp7_pc: got pc %0d state %0d expected 7 1", pc3, state3); end
    step(1);
    n_checks++; if (pc3 !== 3'd0 || state3 !== 3'd2) begin n_fail++; $display("FAIL jmp7_wrap: got pc %0d state %0d expected 0 2", pc3, state3); end
  endtask

  task automatic test_reset_abort;
    int c;
    logic [7:0] v;
    clear_rom;
    rom[0] = enc(4'h1, 1, 0, 0, 8'd9);
    rom[1] = enc(4'h1, 2, 0, 0, 8'd7);
    rom[2] = enc(4'hF, 0, 0, 0, 8'd0);
    do_reset;
    start_run;
    step(1);
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL abort_in_exec: got state %0d expected 2", state); end
    rst = 1'b1;
    run = 1'b1;
    step(1);
    rst = 1'b0;
    run = 1'b0;
    rd_reg(1, v);
    n_checks++; if (state !== 3'd0 || pc !== 6'd0 || v !== 8'h00) begin n_fail++; $display("FAIL abort: got state %0d pc %0d r1 %h expected 0 0 00", state, pc, v); end
    step(3);
    rd_reg(1, v);
    n_checks++; if (state !== 3'd0 || v !== 8'h00) begin n_fail++; $display("FAIL abort_idle: got state %0d r1 %h expected 0 00", state, v); end
    start_run;
    step(1);
    run = 1'b1;
    step(1);
    run = 1'b0;
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL run_busy: got state %0d expected 3", state); end
    wait_halt(40, c);
    c = c + 2;
    rd_reg(1, v);
    n_checks++; if (c !== 9 || pc !== 6'd3 || v !== 8'd9) begin n_fail++; $display("FAIL run_busy_prog: got cycles %0d pc %0d r1 %h expected 9 3 09", c, pc, v); end
  endtask

  task automatic test_in_nop;
    int c;
    logic [7:0] v;
    clear_rom;
    rom[0] = enc(4'h6, 0, 0, 0, 8'h00);
    rom[1] = enc(4'h9, 2, 0, 0, 8'h00);
    rom[2] = enc(4'hA, 0, 2, 0, 8'h00);
    rom[3] = enc(4'hD, 1, 2, 2, 8'h33);
    rom[4] = enc(4'hE, 3, 2, 2, 8'h44);
    rom[5] = enc(4'hF, 0, 0, 0, 8'h00);
    data_in = 8'hA5;
    do_reset;
    start_run;
    step(3);
    n_checks++; if (zf !== 1'b1) begin n_fail++; $display("FAIL xor_zero: got zf %b expected 1", zf); end
    step(3);
    dbg_sel = 2'd2;
    #1;
    n_checks++; if (dbg_data !== 8'hA5 || zf !== 1'b0) begin n_fail++; $display("FAIL in_op: got r2 %h zf %b expected a5 0", dbg_data, zf); end
    step(3);
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL out_op: got %h expected a5", data_out); end
    step(3);
    rd_reg(1, v);
    n_checks++; if (pc !== 6'd4 || v !== 8'h00 || data_out !== 8'hA5 || zf !== 1'b0 || cf !== 1'b0) begin n_fail++; $display("FAIL op_d: got pc %0d r1 %h dout %h zf %b cf %b expected 4 00 a5 0 0", pc, v, data_out, zf, cf); end
    step(3);
    rd_reg(3, v);
    n_checks++; if (pc !== 6'd5 || v !== 8'h00 || zf !== 1'b0) begin n_fail++; $display("FAIL op_e: got pc %0d r3 %h zf %b expected 5 00 0", pc, v, zf); end
    wait_halt(20, c);
    n_checks++; if (halted !== 1'b1 || pc !== 6'd6) begin n_fail++; $display("FAIL in_nop_halt: got halted %b pc %0d expected 1 6", halted, pc); end
  endtask

  initial begin
    rst     = 1'b1;
    run     = 1'b0;
    rst3    = 1'b1;
    run3    = 1'b0;
    data_in = 8'h00;
    dbg_sel = 2'd0;
    for (int i = 0; i < 64; i++) rom[i] = '0;
    for (int i = 0; i < 8; i++) rom3[i] = '0;
    step(1);
    test_reset;
    test_program;
    test_arith;
    test_loop;
    test_wrap;
    test_reset_abort;
    test_in_nop;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
